// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character-LCD text controller.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - HD44780 command bytes and the blank character code
//   - small helpers for address widths and DDRAM line addresses
// No ports (package).
package lcd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_PWRUP   = 3'd0;
    localparam state_t S_FUNC    = 3'd1;
    localparam state_t S_CLEAR   = 3'd2;
    localparam state_t S_DISP_ON = 3'd3;
    localparam state_t S_ENTRY   = 3'd4;
    localparam state_t S_ADDR    = 3'd5;
    localparam state_t S_CHAR    = 3'd6;
    localparam state_t S_IDLE    = 3'd7;

    localparam logic [7:0] FUNC_2L    = 8'h38;
    localparam logic [7:0] FUNC_1L    = 8'h30;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY      = 8'h06;
    localparam logic [7:0] SET_DDRAM  = 8'h80;
    localparam logic [7:0] LINE1_BASE = 8'h40;
    localparam logic [7:0] SPACE      = 8'h20;

    // Width needed to index 0..depth-1, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Set-DDRAM-address command for the start of a given line.
    function automatic logic [7:0] line_addr_cmd(input logic line);
        return SET_DDRAM | (line ? LINE1_BASE : 8'h00);
    endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// lcd_text_ctrl_if: host-side character-buffer write bus.
//   wr_en    host -> ctrl  one character written per cycle while high
//   wr_addr  host -> ctrl  buffer index = line*COLS + col
//   wr_data  host -> ctrl  ASCII / CGROM code
// With LCD_CLEAR_REQ_EN defined the bus also carries:
//   clr_req  host -> ctrl  pulse to start a buffer fill with spaces
//   clr_busy ctrl -> host  high while that fill is running
// Modports: master (host side), slave (controller side).
interface lcd_text_ctrl_if #(
    parameter int AW = 5
) ();
    import lcd_pkg::*;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
`ifdef LCD_CLEAR_REQ_EN
    logic          clr_req;
    logic          clr_busy;

    modport master (output wr_en, output wr_addr, output wr_data,
                    output clr_req, input clr_busy);
    modport slave  (input wr_en, input wr_addr, input wr_data,
                    input clr_req, output clr_busy);
`else
    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input wr_en, input wr_addr, input wr_data);
`endif

endinterface

// File: rtl/lcd_step_timer.sv
// lcd_step_timer: free-running LCD bus step counter.
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   boundary  out  high on the last cycle of a step; the next edge starts a step
//   en_next   out  enable window evaluated for the count of the next cycle,
//                  so a register fed from it is high for step_cnt in
//                  [STEP_CYCLES/4, 3*STEP_CYCLES/4)
module lcd_step_timer
    import lcd_pkg::*;
#(
    parameter int STEP_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    output logic boundary,
    output logic en_next
);

    localparam int CW = addr_width(STEP_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] EN_LO = CW'(STEP_CYCLES / 4);
    localparam logic [CW-1:0] EN_HI = CW'((3 * STEP_CYCLES) / 4);

    logic [CW-1:0] step_cnt;
    logic [CW-1:0] cnt_next;

    // Looking one cycle ahead lets the caller register lcd_en without
    // shifting the window by a cycle.
    always_comb begin
        boundary = (step_cnt == LAST);
        cnt_next = boundary ? '0 : step_cnt + CW'(1);
        en_next  = (cnt_next >= EN_LO) && (cnt_next < EN_HI);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: HD44780-class character LCD controller, 8-bit write-only.
// Holds a NUM_LINES x COLS character buffer, runs power-up and init, then
// refreshes the glass continuously from the buffer.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   host        lcd_text_ctrl_if.slave  buffer write bus
//   init_done   out  high once the entry-mode command has been issued
//   frame_tick  out  one-cycle pulse when a refresh frame ends
//   lcd_rs      out  register select (0 command, 1 data)
//   lcd_rw      out  tied 0
//   lcd_en      out  enable strobe
//   lcd_data    out  LCD data bus
// Optional: define LCD_CLEAR_REQ_EN to add clr_req/clr_busy on the host bus
// for a sequential space-fill of the buffer.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ        = 54_000_000,
    parameter int STEP_US       = 5000,
    parameter int PWRUP_STEPS   = 20,
    parameter int NUM_LINES     = 2,
    parameter int COLS          = 16,
    parameter int REFRESH_STEPS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_text_ctrl_if.slave        host,
    output logic                  init_done,
    output logic                  frame_tick,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_en,
    output logic [7:0]            lcd_data
);

    localparam int STEP_CYCLES = CLK_HZ / 1_000_000 * STEP_US;
    localparam int DEPTH       = NUM_LINES * COLS;
    localparam int AW          = addr_width(DEPTH);
    localparam int COLW        = addr_width(COLS);
    localparam int SUB_MAX     = (PWRUP_STEPS > REFRESH_STEPS) ? PWRUP_STEPS : REFRESH_STEPS;
    localparam int SUBW        = addr_width(SUB_MAX);

    localparam logic [AW:0]     DEPTH_W      = (AW + 1)'(DEPTH);
    localparam logic [COLW-1:0] COL_LAST     = COLW'(COLS - 1);
    localparam logic [SUBW-1:0] PWRUP_LAST   = SUBW'(PWRUP_STEPS - 1);
    localparam logic [SUBW-1:0] REFRESH_LAST = SUBW'(REFRESH_STEPS - 1);

    logic            boundary;
    logic            en_next;

    state_t          state;
    logic [SUBW-1:0] sub_cnt;
    logic            line;
    logic [COLW-1:0] col;
    logic [COLW-1:0] col_next;
    logic            last_line;
    logic [AW-1:0]   rd_idx;
    logic [7:0]      rd_char;
    logic            wr_ok;

    logic [7:0]      char_mem [DEPTH];

    lcd_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .boundary (boundary),
        .en_next  (en_next)
    );

    assign lcd_rw = 1'b0;

    // Index of the character that will be latched at the coming boundary:
    // column 0 when leaving S_ADDR, otherwise the next column of this line.
    always_comb begin
        col_next  = (state == S_ADDR) ? '0 : col + COLW'(1);
        last_line = (NUM_LINES == 1) || line;
        rd_idx    = AW'(int'(line) * COLS + int'(col_next));
        rd_char   = char_mem[rd_idx];
        wr_ok     = host.wr_en && ({1'b0, host.wr_addr} < DEPTH_W);
    end

`ifdef LCD_CLEAR_REQ_EN
    localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);

    logic          clr_busy_q;
    logic [AW-1:0] clr_idx;

    assign host.clr_busy = clr_busy_q;

    // Character buffer. A fill walks one entry per cycle and locks out host
    // writes; a clr_req seen during a fill is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                char_mem[i] <= SPACE;
            end
            clr_busy_q <= 1'b0;
            clr_idx    <= '0;
        end else if (clr_busy_q) begin
            char_mem[clr_idx] <= SPACE;
            if (clr_idx == DEPTH_LAST) begin
                clr_busy_q <= 1'b0;
            end else begin
                clr_idx <= clr_idx + AW'(1);
            end
        end else begin
            if (wr_ok) begin
                char_mem[host.wr_addr] <= host.wr_data;
            end
            if (host.clr_req) begin
                clr_busy_q <= 1'b1;
                clr_idx    <= '0;
            end
        end
    end
`else
    // Character buffer. Reads happen through rd_char, so a write landing on
    // the same edge as a latch is only seen on the following frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                char_mem[i] <= SPACE;
            end
        end else if (wr_ok) begin
            char_mem[host.wr_addr] <= host.wr_data;
        end
    end
`endif

    // Sequencer. Every state change and every load of lcd_rs/lcd_data
    // happens on a step boundary, so the bus is stable for a whole step and
    // lcd_en (which falls before the boundary) strobes mid-step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_PWRUP;
            sub_cnt    <= '0;
            line       <= 1'b0;
            col        <= '0;
            lcd_rs     <= 1'b0;
            lcd_data   <= '0;
            lcd_en     <= 1'b0;
            init_done  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            lcd_en     <= en_next && (state != S_PWRUP) && (state != S_IDLE);
            if (boundary) begin
                case (state)
                    S_PWRUP: begin
                        if (sub_cnt == PWRUP_LAST) begin
                            sub_cnt  <= '0;
                            state    <= S_FUNC;
                            lcd_rs   <= 1'b0;
                            lcd_data <= (NUM_LINES == 2) ? FUNC_2L : FUNC_1L;
                        end else begin
                            sub_cnt <= sub_cnt + SUBW'(1);
                        end
                    end
                    S_FUNC: begin
                        state    <= S_CLEAR;
                        lcd_data <= CLEAR;
                    end
                    S_CLEAR: begin
                        state    <= S_DISP_ON;
                        lcd_data <= DISP_ON;
                    end
                    S_DISP_ON: begin
                        state    <= S_ENTRY;
                        lcd_data <= ENTRY;
                    end
                    S_ENTRY: begin
                        state     <= S_ADDR;
                        line      <= 1'b0;
                        lcd_data  <= line_addr_cmd(1'b0);
                        init_done <= 1'b1;
                    end
                    S_ADDR: begin
                        state    <= S_CHAR;
                        col      <= col_next;
                        lcd_rs   <= 1'b1;
                        lcd_data <= rd_char;
                    end
                    S_CHAR: begin
                        if (col == COL_LAST) begin
                            lcd_rs <= 1'b0;
                            if (last_line) begin
                                state    <= S_IDLE;
                                sub_cnt  <= '0;
                                lcd_data <= '0;
                            end else begin
                                state    <= S_ADDR;
                                line     <= 1'b1;
                                lcd_data <= line_addr_cmd(1'b1);
                            end
                        end else begin
                            col      <= col_next;
                            lcd_data <= rd_char;
                        end
                    end
                    S_IDLE: begin
                        if (sub_cnt == REFRESH_LAST) begin
                            sub_cnt    <= '0;
                            state      <= S_ADDR;
                            line       <= 1'b0;
                            lcd_data   <= line_addr_cmd(1'b0);
                            frame_tick <= 1'b1;
                        end else begin
                            sub_cnt <= sub_cnt + SUBW'(1);
                        end
                    end
                    default: begin
                        state <= S_PWRUP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb_lcd_text_ctrl: directed, scoreboard-based bench for lcd_text_ctrl.
// Instance 0: 2 lines x 4 columns; instance 1: 1 line x 3 columns, which also
// has unused address codes so an out-of-range write can be issued.
// Both run at 8 clock cycles per bus step with 3 power-up steps.
// Build with LCD_CLEAR_REQ_EN defined to also exercise the clear request.
`timescale 1ns/1ps
module tb_lcd_text_ctrl;
    import lcd_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic       init_done0, frame_tick0, lcd_rs0, lcd_rw0, lcd_en0;
    logic [7:0] lcd_data0;
    logic       init_done1, frame_tick1, lcd_rs1, lcd_rw1, lcd_en1;
    logic [7:0] lcd_data1;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    logic [8:0] exp0_q [$];
    logic [8:0] exp1_q [$];

    lcd_text_ctrl_if #(.AW(3)) bus0 ();
    lcd_text_ctrl_if #(.AW(2)) bus1 ();

    lcd_text_ctrl #(
        .CLK_HZ(1_000_000), .STEP_US(8), .PWRUP_STEPS(3),
        .NUM_LINES(2), .COLS(4), .REFRESH_STEPS(2)
    ) u_dut0 (
        .clk(clk), .reset(reset), .host(bus0),
        .init_done(init_done0), .frame_tick(frame_tick0),
        .lcd_rs(lcd_rs0), .lcd_rw(lcd_rw0), .lcd_en(lcd_en0), .lcd_data(lcd_data0)
    );

    lcd_text_ctrl #(
        .CLK_HZ(1_000_000), .STEP_US(8), .PWRUP_STEPS(3),
        .NUM_LINES(1), .COLS(3), .REFRESH_STEPS(2)
    ) u_dut1 (
        .clk(clk), .reset(reset), .host(bus1),
        .init_done(init_done1), .frame_tick(frame_tick1),
        .lcd_rs(lcd_rs1), .lcd_rw(lcd_rw1), .lcd_en(lcd_en1), .lcd_data(lcd_data1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Strobe monitors: on each lcd_en fall, pop one expected {rs,data} entry
    // and check it together with rw and the enable pulse width.
    logic en_prev0 = 1'b0;
    int   en_w0    = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (en_prev0 && !lcd_en0 && exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            check_output("strobe0", 32'({lcd_rw0, lcd_rs0, lcd_data0}), 32'({1'b0, e}));
            check_output("en_width0", 32'(en_w0), 32'd4);
        end
        en_w0    = lcd_en0 ? (en_prev0 ? en_w0 + 1 : 1) : en_w0;
        en_prev0 = lcd_en0;
    end

    logic en_prev1 = 1'b0;
    int   en_w1    = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (en_prev1 && !lcd_en1 && exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            check_output("strobe1", 32'({lcd_rw1, lcd_rs1, lcd_data1}), 32'({1'b0, e}));
            check_output("en_width1", 32'(en_w1), 32'd4);
        end
        en_w1    = lcd_en1 ? (en_prev1 ? en_w1 + 1 : 1) : en_w1;
        en_prev1 = lcd_en1;
    end

    // Frame of instance 0: chars = {c0,c1,c2,c3 (line 0), c4..c7 (line 1)}.
    task automatic push_frame0(input logic [63:0] chars);
        exp0_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 4; i++) exp0_q.push_back({1'b1, chars[63 - 8*i -: 8]});
        exp0_q.push_back({1'b0, 8'hC0});
        for (int i = 4; i < 8; i++) exp0_q.push_back({1'b1, chars[63 - 8*i -: 8]});
    endtask

    task automatic push_frame1(input logic [23:0] chars);
        exp1_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 3; i++) exp1_q.push_back({1'b1, chars[23 - 8*i -: 8]});
    endtask

    task automatic push_init;
        exp0_q.push_back({1'b0, 8'h38});
        exp0_q.push_back({1'b0, 8'h01});
        exp0_q.push_back({1'b0, 8'h0C});
        exp0_q.push_back({1'b0, 8'h06});
        push_frame0({8{8'h20}});
        exp1_q.push_back({1'b0, 8'h30});
        exp1_q.push_back({1'b0, 8'h01});
        exp1_q.push_back({1'b0, 8'h0C});
        exp1_q.push_back({1'b0, 8'h06});
        push_frame1({3{8'h20}});
    endtask

    // One host write on the chosen instance, held for exactly one edge.
    task automatic apply_stimulus(input int which, input int addr, input logic [7:0] data);
        @(negedge clk);
        if (which == 0) begin
            bus0.wr_en = 1'b1; bus0.wr_addr = 3'(addr); bus0.wr_data = data;
        end else begin
            bus1.wr_en = 1'b1; bus1.wr_addr = 2'(addr); bus1.wr_data = data;
        end
        @(negedge clk);
        bus0.wr_en = 1'b0;
        bus1.wr_en = 1'b0;
    endtask

    // Returns on the negedge where frame_tick of the chosen instance is high.
    task automatic wait_tick(input int which, output longint t);
        int   n = 0;
        logic ft;
        do begin
            @(negedge clk);
            n++;
            ft = (which == 0) ? frame_tick0 : frame_tick1;
        end while (ft !== 1'b1 && n < 400);
        check_output((which == 0) ? "tick0_seen" : "tick1_seen", 32'(ft), 32'd1);
        t = cyc;
    endtask

    task automatic drain(input int which);
        int n = 0;
        while (((which == 0) ? exp0_q.size() : exp1_q.size()) > 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_output((which == 0) ? "drain0" : "drain1",
                     32'((which == 0) ? exp0_q.size() : exp1_q.size()), 32'd0);
    endtask

    initial begin
        #300_000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint t1, t2;
        int     n;
        int     en_hi;

        bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
        bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
`ifdef LCD_CLEAR_REQ_EN
        bus0.clr_req = 1'b0;
        bus1.clr_req = 1'b0;
`endif

        // Reset state.
        repeat (4) @(negedge clk);
        check_output("reset_outputs0",
                     32'({lcd_rs0, lcd_rw0, lcd_en0, lcd_data0, init_done0, frame_tick0}), 32'd0);
        check_output("reset_outputs1",
                     32'({lcd_rs1, lcd_rw1, lcd_en1, lcd_data1, init_done1, frame_tick1}), 32'd0);
`ifdef LCD_CLEAR_REQ_EN
        check_output("reset_clr_busy", 32'(bus0.clr_busy), 32'd0);
`endif

        // Scenario 1: power-up quiet period, then init + first frame.
        reset = 1'b1;
        push_init();
        en_hi = 0;
        for (int i = 0; i < 24; i++) begin
            if (lcd_en0 || lcd_en1) en_hi++;
            @(negedge clk);
        end
        check_output("pwrup_quiet", 32'(en_hi), 32'd0);

        n = 0;
        while (exp0_q.size() > 10 && n < 200) begin @(negedge clk); n++; end
        check_output("init_done_before_entry_end", 32'(init_done0), 32'd0);
        n = 0;
        while (exp0_q.size() > 9 && n < 200) begin @(negedge clk); n++; end
        check_output("init_done_after_entry", 32'(init_done0), 32'd1);
        check_output("init_done1_after_entry", 32'(init_done1), 32'd1);
        drain(0);
        drain(1);

        // Scenario 2: "AB" at 0..1, "Z" at 7; check enable placement in a step.
        apply_stimulus(0, 0, 8'h41);
        apply_stimulus(0, 1, 8'h42);
        apply_stimulus(0, 7, 8'h5A);
        wait_tick(0, t1);
        push_frame0({8'h41, 8'h42, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h5A});
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("en_window_cycle%0d", i), 32'(lcd_en0),
                         32'((i >= 2 && i < 6) ? 1 : 0));
            @(negedge clk);
        end
        drain(0);

        // Scenario 3: out-of-range write (addr 3 of a 3-entry buffer) is
        // dropped while an in-range one lands.
        apply_stimulus(1, 3, 8'h55);
        apply_stimulus(1, 1, 8'h31);
        wait_tick(1, t1);
        push_frame1({8'h20, 8'h31, 8'h20});
        drain(1);

        // Scenario 4: write addr 2 on the very edge that latches it.
        wait_tick(0, t1);
        push_frame0({8'h41, 8'h42, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h5A});
        repeat (23) @(negedge clk);
        bus0.wr_en = 1'b1; bus0.wr_addr = 3'd2; bus0.wr_data = 8'h58;
        @(negedge clk);
        bus0.wr_en = 1'b0;
        wait_tick(0, t2);
        check_output("frame_tick_spacing", 32'(t2 - t1), 32'd96);
        push_frame0({8'h41, 8'h42, 8'h58, 8'h20, 8'h20, 8'h20, 8'h20, 8'h5A});
        drain(0);

        // Scenario 5: asynchronous reset in the middle of a character step.
        wait_tick(0, t1);
        repeat (11) @(negedge clk);
        check_output("pre_reset_en", 32'({lcd_en0, lcd_rs0}), 32'd3);
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_outputs0",
                     32'({lcd_rs0, lcd_rw0, lcd_en0, lcd_data0, init_done0, frame_tick0}), 32'd0);
        check_output("async_reset_outputs1",
                     32'({lcd_rs1, lcd_rw1, lcd_en1, lcd_data1, init_done1, frame_tick1}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        push_init();
        check_output("init_done_cleared", 32'(init_done0), 32'd0);
        drain(0);
        drain(1);

`ifdef LCD_CLEAR_REQ_EN
        // Scenario 6: fill the buffer, clear it, try a write mid-clear.
        for (int i = 0; i < 8; i++) apply_stimulus(0, i, 8'(8'h61 + i));
        wait_tick(0, t1);
        bus0.clr_req = 1'b1;
        @(negedge clk);
        bus0.clr_req = 1'b0;
        n = 0;
        while (bus0.clr_busy === 1'b1 && n < 20) begin
            n++;
            if (n == 4) begin
                bus0.wr_en = 1'b1; bus0.wr_addr = 3'd0; bus0.wr_data = 8'h77;
            end else begin
                bus0.wr_en = 1'b0;
            end
            @(negedge clk);
        end
        bus0.wr_en = 1'b0;
        check_output("clr_busy_cycles", 32'(n), 32'd8);
        wait_tick(0, t1);
        push_frame0({8{8'h20}});
        drain(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
